// File: rtl/pipe_skid_reg.sv
// Pipeline register stage with valid/ready handshake and a two-entry skid buffer.
// in_ready comes straight from a flop, so out_ready never reaches in_ready combinationally.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CE,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic push, pop, stall;

  assign push  = CE & in_valid & in_ready_q;
  assign pop   = CE & out_valid_q & out_ready;
  assign stall = CE & out_valid_q & ~out_ready;

  // NOTE: every variable gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;

    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (CE) begin
      if (flush) begin
        // A concurrent pop is still consumed downstream; a concurrent push is dropped.
        state_d = ST_EMPTY;
        main_d  = RST_VAL;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (push) begin
              main_d  = D;
              state_d = ST_ONE;
            end
          end
          ST_ONE: begin
            if (push && pop) begin
              main_d = D;
            end else if (pop) begin
              state_d = ST_EMPTY;
            end else if (push) begin
              skid_d  = D;
              state_d = ST_FULL;
            end
          end
          ST_FULL: begin
            if (pop) begin
              main_d  = skid_q;
              state_d = ST_ONE;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= RST_VAL;
      skid_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Q         = main_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg against a queue-based reference model.
module tb_pipe_skid_reg;

  localparam int unsigned      WIDTH   = 32;
  localparam logic [WIDTH-1:0] RST_VAL = 32'h0BAD_F00D;
  localparam int unsigned      CNT_W   = 4;
  localparam int               CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             CE, flush, in_valid, out_ready;
  logic [WIDTH-1:0] D;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] Q;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the accepted-but-not-consumed beats, the value shown on Q, the stall count.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] q_exp;
  int               cnt_exp;

  pipe_skid_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VAL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .CE(CE), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .D(D),
    .out_valid(out_valid), .out_ready(out_ready), .Q(Q), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/Q"},         Q,         q_exp);
    check({tag, "/out_valid"}, out_valid, 32'(mq.size() > 0));
    check({tag, "/in_ready"},  in_ready,  32'(mq.size() < 2));
    check({tag, "/stall_cnt"}, stall_cnt, 32'(cnt_exp));
  endtask

  task automatic model_reset();
    mq.delete();
    q_exp   = RST_VAL;
    cnt_exp = 0;
  endtask

  task automatic cycle(input string tag, input bit ce, input bit fl, input bit iv,
                       input logic [WIDTH-1:0] d, input bit ordy, output bit pushed);
    bit push, pop, stall;
    CE = ce; flush = fl; in_valid = iv; D = d; out_ready = ordy;
    push  = ce && iv && (mq.size() < 2);
    pop   = ce && (mq.size() > 0) && ordy;
    stall = ce && (mq.size() > 0) && !ordy;
    @(posedge clk);
    #1;
    pushed = 1'b0;
    if (ce) begin
      if (stall && cnt_exp < CNT_MAX) cnt_exp++;
      if (fl) begin
        mq.delete();
        q_exp = RST_VAL;
      end else begin
        if (pop)  void'(mq.pop_front());
        if (push) begin
          mq.push_back(d);
          pushed = 1'b1;
        end
        if (mq.size() > 0) q_exp = mq[0];
      end
    end
    check_all(tag);
  endtask

  task automatic step(input string tag, input bit ce, input bit fl, input bit iv,
                      input logic [WIDTH-1:0] d, input bit ordy);
    bit dummy;
    cycle(tag, ce, fl, iv, d, ordy, dummy);
  endtask

  task automatic fill_full();
    step("fill_empty", 1, 0, 0, 32'h0, 1);
    step("fill_empty", 1, 0, 0, 32'h0, 1);
    step("fill_a",     1, 0, 1, 32'hA, 0);
    step("fill_b",     1, 0, 1, 32'hB, 0);
  endtask

  initial begin
    bit               pend_v, pushed;
    logic [WIDTH-1:0] pend_d;

    // Reset held with random inputs.
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      CE = 1'($urandom); flush = 1'($urandom); in_valid = 1'($urandom);
      D = $urandom; out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      check("reset/Q",         Q,         RST_VAL);
      check("reset/out_valid", out_valid, 32'd0);
      check("reset/in_ready",  in_ready,  32'd1);
      check("reset/stall_cnt", stall_cnt, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    step("first_push", 1, 0, 1, 32'hDEAD_BEEF, 1);
    check("first_push/Q_lit", Q, 32'hDEAD_BEEF);

    for (int i = 1; i <= 100; i++) begin
      step("stream", 1, 0, 1, 32'(i), 1);
    end
    step("stream_drain", 1, 0, 0, 32'h0, 1);

    fill_full();
    check("skid/in_ready_lit", in_ready, 32'd0);
    check("skid/Q_lit",        Q,        32'hA);
    for (int i = 0; i < 3; i++) step("skid_hold", 1, 0, 0, 32'h0, 0);
    step("skid_pop_a", 1, 0, 0, 32'h0, 1);
    check("skid/Q_b_lit", Q, 32'hB);
    step("skid_pop_b", 1, 0, 0, 32'h0, 1);

    fill_full();
    step("flush_full", 1, 1, 1, 32'hC, 0);
    check("flush/Q_lit", Q, RST_VAL);
    step("after_flush", 1, 0, 0, 32'h0, 1);
    step("after_flush", 1, 0, 0, 32'h0, 1);

    fill_full();
    for (int i = 0; i < 5; i++) step("ce_off", 0, 1, 1, $urandom, 1);
    step("ce_resume", 1, 0, 0, 32'h0, 1);
    step("ce_resume", 1, 0, 0, 32'h0, 1);

    fill_full();
    for (int i = 0; i < 20; i++) step("saturate", 1, 0, 0, 32'h0, 0);
    check("saturate/lit", stall_cnt, 32'(CNT_MAX));

    // Asynchronous reset asserted between edges while FULL; CE low keeps the idle edge a no-op.
    CE = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    rst = 1'b1;

    // Random traffic with an upstream that holds its beat until accepted.
    pend_v = 1'b0;
    pend_d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend_v && $urandom_range(0, 1) == 1) begin
        pend_v = 1'b1;
        pend_d = $urandom;
      end
      cycle("random", $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
            pend_v, pend_d, 1'($urandom), pushed);
      if (pushed) pend_v = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
